// File: rtl/pp_counter_scan_display.sv
// Ping-pong / wrap counter between runtime bounds with a 4-digit seven-segment scan driver.
// Define PP_BCD_DISPLAY_EN to show the count in decimal (out % 100) instead of hex.
module pp_counter_scan_display #(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flip,
    input  logic             mode,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic [3:0]       AN,
    output logic [6:0]       segs
);

    localparam logic [6:0] GLYPH_UP   = 7'b0011100;
    localparam logic [6:0] GLYPH_DOWN = 7'b0100011;

    logic                valid;
    logic                eff_dir;
    logic [WIDTH-1:0]    out_next;
    logic                dir_next;
    logic [SCAN_DIV-1:0] refresh;
    logic [1:0]          sel;
    logic [7:0]          out_ext;
    logic [3:0]          an_next;
    logic [6:0]          segs_next;

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

`ifdef PP_BCD_DISPLAY_EN
    // Hundreds are dropped: only out % 100 is shown.
    function automatic logic [3:0] digit_lo(input logic [7:0] v);
        logic [7:0] m;
        m = v % 8'd100;
        return 4'(m % 8'd10);
    endfunction

    function automatic logic [3:0] digit_hi(input logic [7:0] v);
        logic [7:0] m;
        m = v % 8'd100;
        return 4'(m / 8'd10);
    endfunction
`else
    function automatic logic [3:0] digit_lo(input logic [7:0] v);
        return v[3:0];
    endfunction

    function automatic logic [3:0] digit_hi(input logic [7:0] v);
        return v[7:4];
    endfunction
`endif

    // Counter step: a flip pulse is folded into the direction used on this same edge.
    always_comb begin
        out_next = out;
        dir_next = direction;
        valid    = enable && (max > min) && (out >= min) && (out <= max);
        eff_dir  = direction ^ flip;
        if (valid) begin
            if (eff_dir) begin
                if (out < max) begin
                    out_next = out + WIDTH'(1);
                    dir_next = 1'b1;
                end else if (mode) begin
                    out_next = min;
                    dir_next = 1'b1;
                end else begin
                    out_next = max - WIDTH'(1);
                    dir_next = 1'b0;
                end
            end else begin
                if (out > min) begin
                    out_next = out - WIDTH'(1);
                    dir_next = 1'b0;
                end else if (mode) begin
                    out_next = max;
                    dir_next = 1'b0;
                end else begin
                    out_next = min + WIDTH'(1);
                    dir_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= min;
            direction <= 1'b1;
        end else begin
            out       <= out_next;
            direction <= dir_next;
        end
    end

    assign sel     = refresh[SCAN_DIV-1 -: 2];
    assign out_ext = 8'(out);

    always_comb begin
        an_next   = 4'b1110;
        segs_next = hex_glyph(digit_lo(out_ext));
        case (sel)
            2'd0: begin
                an_next   = 4'b1110;
                segs_next = hex_glyph(digit_lo(out_ext));
            end
            2'd1: begin
                an_next   = 4'b1101;
                segs_next = hex_glyph(digit_hi(out_ext));
            end
            2'd2: begin
                an_next   = 4'b1011;
                segs_next = direction ? GLYPH_UP : GLYPH_DOWN;
            end
            default: begin
                an_next   = 4'b0111;
                segs_next = direction ? GLYPH_UP : GLYPH_DOWN;
            end
        endcase
    end

    // Reset shows digit 0 of min straight away, matching what out is loaded with.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh <= '0;
            AN      <= 4'b1110;
            segs    <= hex_glyph(digit_lo(8'(min)));
        end else begin
            refresh <= refresh + SCAN_DIV'(1);
            AN      <= an_next;
            segs    <= segs_next;
        end
    end

endmodule

// File: tb/tb_pp_counter_scan_display.sv
// Directed bench for pp_counter_scan_display (WIDTH=8, SCAN_DIV=2).
module tb_pp_counter_scan_display;

    localparam int WIDTH    = 8;
    localparam int SCAN_DIV = 2;

    localparam logic [6:0] G0      = 7'b1000000;
    localparam logic [6:0] G1      = 7'b1111001;
    localparam logic [6:0] G2      = 7'b0100100;
    localparam logic [6:0] G4      = 7'b0011001;
    localparam logic [6:0] G5      = 7'b0010010;
    localparam logic [6:0] G7      = 7'b1111000;
    localparam logic [6:0] G9      = 7'b0010000;
    localparam logic [6:0] GA      = 7'b0001000;
    localparam logic [6:0] GC      = 7'b1000110;
    localparam logic [6:0] G_UP    = 7'b0011100;
    localparam logic [6:0] G_DOWN  = 7'b0100011;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             flip;
    logic             mode;
    logic [WIDTH-1:0] max;
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] out;
    logic             direction;
    logic [3:0]       AN;
    logic [6:0]       segs;

    int n_checks = 0;
    int n_fail   = 0;

    pp_counter_scan_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flip(flip), .mode(mode),
        .max(max), .min(min), .out(out), .direction(direction),
        .AN(AN), .segs(segs)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; flip = 1'b0; mode = 1'b0;
        min = 8'd0; max = 8'd4;
        tick();
        n_checks++;
        if (out !== 8'd0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", out); end
        n_checks++;
        if (direction !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b expected 1", direction); end
        n_checks++;
        if (AN !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b expected 1110", AN); end
        n_checks++;
        if (segs !== G0) begin n_fail++; $display("FAIL reset_segs: got %b expected %b", segs, G0); end
        rst = 1'b0;
    endtask

    task automatic test_pingpong();
        logic [7:0] exp_o [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
        logic       exp_d [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (out !== exp_o[i] || direction !== exp_d[i]) begin
                n_fail++;
                $display("FAIL pingpong step %0d: got out=%0d dir=%b expected out=%0d dir=%b",
                         i, out, direction, exp_o[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_flip();
        logic       fl    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp_o [4] = '{8'd2, 8'd1, 8'd0, 8'd1};
        logic       exp_d [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            flip = fl[i];
            tick();
            n_checks++;
            if (out !== exp_o[i] || direction !== exp_d[i]) begin
                n_fail++;
                $display("FAIL flip step %0d: got out=%0d dir=%b expected out=%0d dir=%b",
                         i, out, direction, exp_o[i], exp_d[i]);
            end
        end
        flip = 1'b0;
    endtask

    task automatic test_wrap();
        logic       fl    [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] exp_o [4] = '{8'd2, 8'd3, 8'd1, 8'd3};
        logic       exp_d [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        mode = 1'b1; min = 8'd1; max = 8'd3;
        for (int i = 0; i < 4; i++) begin
            flip = fl[i];
            tick();
            n_checks++;
            if (out !== exp_o[i] || direction !== exp_d[i]) begin
                n_fail++;
                $display("FAIL wrap step %0d: got out=%0d dir=%b expected out=%0d dir=%b",
                         i, out, direction, exp_o[i], exp_d[i]);
            end
        end
        flip = 1'b0;
    endtask

    task automatic test_bounds();
        logic [7:0] mn    [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd5, 8'd1};
        logic [7:0] mx    [6] = '{8'd3, 8'd2, 8'd1, 8'd1, 8'd9, 8'd3};
        logic       fl    [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp_o [6] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1};
        for (int i = 0; i < 6; i++) begin
            min = mn[i]; max = mx[i]; flip = fl[i];
            tick();
            n_checks++;
            if (out !== exp_o[i] || direction !== 1'b0) begin
                n_fail++;
                $display("FAIL bounds step %0d: got out=%0d dir=%b expected out=%0d dir=0",
                         i, out, direction, exp_o[i]);
            end
        end
        flip = 1'b0;
    endtask

    // Counter is at out=1, direction down; rotation of AN is checked cycle to cycle.
    task automatic test_hold_enable();
        logic [3:0] prev_an;
        logic [3:0] exp_an;
        logic [6:0] exp_segs;
        prev_an = AN;
        enable  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flip = (i == 2);
            tick();
            exp_an = {prev_an[2:0], prev_an[3]};
            case (exp_an)
                4'b1110: exp_segs = G1;
                4'b1101: exp_segs = G0;
                default: exp_segs = G_DOWN;
            endcase
            n_checks++;
            if (out !== 8'd1 || direction !== 1'b0) begin
                n_fail++;
                $display("FAIL hold step %0d: got out=%0d dir=%b expected out=1 dir=0", i, out, direction);
            end
            n_checks++;
            if (AN !== exp_an) begin
                n_fail++;
                $display("FAIL hold_an step %0d: got %b expected %b", i, AN, exp_an);
            end
            n_checks++;
            if (segs !== exp_segs) begin
                n_fail++;
                $display("FAIL hold_segs step %0d: got %b expected %b", i, segs, exp_segs);
            end
            prev_an = AN;
        end
        flip = 1'b0;
    endtask

    task automatic test_display(input logic [7:0] value, input logic [6:0] g_lo, input logic [6:0] g_hi);
        logic [3:0] exp_an   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] exp_segs [4];
        exp_segs = '{g_lo, g_hi, G_UP, G_UP};
        rst = 1'b1; enable = 1'b0; flip = 1'b0; mode = 1'b0;
        min = value; max = 8'hFF;
        tick();
        rst = 1'b0;
        n_checks++;
        if (out !== value || direction !== 1'b1 || AN !== 4'b1110 || segs !== g_lo) begin
            n_fail++;
            $display("FAIL display_reset %h: got out=%h dir=%b an=%b segs=%b expected out=%h dir=1 an=1110 segs=%b",
                     value, out, direction, AN, segs, value, g_lo);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (AN !== exp_an[i] || segs !== exp_segs[i]) begin
                n_fail++;
                $display("FAIL display %h digit %0d: got an=%b segs=%b expected an=%b segs=%b",
                         value, i, AN, segs, exp_an[i], exp_segs[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flip = 1'b0; mode = 1'b0;
        min = '0; max = '0;
        test_reset();
        test_pingpong();
        test_flip();
        test_wrap();
        test_bounds();
        test_hold_enable();
`ifdef PP_BCD_DISPLAY_EN
        test_display(8'h2A, G2, G4);
        test_display(8'hC5, G7, G9);
`else
        test_display(8'h2A, GA, G2);
        test_display(8'hC5, G5, GC);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
